// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiply-accumulate unit.
package mul_pkg;

    localparam int MUL_N = 16;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier-accumulator: {mul_hi, mul_rd} = rs1_reg * rs2_reg + acc_in,
// one partial product per clock, fixed N-cycle latency. Used to rebuild a dividend
// from the quotient/divisor/remainder produced by the div unit.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  MUL_IDLE | waiting for start; result outputs hold the last result
//  MUL_RUN  | one shift-add step per cycle, N steps, then back to idle
module mul_seq
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] rs1_reg,
    input  logic [N-1:0] rs2_reg,
    input  logic [N-1:0] acc_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] mul_rd,
    output logic [N-1:0] mul_hi
);

    localparam int CW = $clog2(N) + 1;

    mul_state_e     state;
    mul_state_e     state_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] acc_sum;
    logic           last_step;

    // The final step both accumulates and publishes, so done lands on the N-th edge.
    assign last_step = (cnt == CW'(N - 1));
    assign busy      = (state == MUL_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start is only honoured from idle.
    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_RUN;
            MUL_RUN:  if (last_step) state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    // Partial product selected by the current multiplier LSB, aligned by the step count.
    always_comb begin
        addend  = '0;
        if (mplier[0]) addend = {{N{1'b0}}, mcand} << cnt;
        acc_sum = acc + addend;
    end

    // Operand latch, shift-add datapath and result/done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            mul_rd <= '0;
            mul_hi <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= rs1_reg;
                        mplier <= rs2_reg;
                        acc    <= {{N{1'b0}}, acc_in};
                        cnt    <= '0;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        mul_rd <= acc_sum[N-1:0];
                        mul_hi <= acc_sum[2*N-1:N];
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver pushes arithmetic expectations, a monitor
// pops and compares on every done pulse and checks the outputs hold in between.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int N = MUL_N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] rs1_reg = '0;
    logic [N-1:0] rs2_reg = '0;
    logic [N-1:0] acc_in = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] mul_rd;
    logic [N-1:0] mul_hi;

    mul_seq #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rs1_reg (rs1_reg),
        .rs2_reg (rs2_reg),
        .acc_in  (acc_in),
        .busy    (busy),
        .done    (done),
        .mul_rd  (mul_rd),
        .mul_hi  (mul_hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2*N-1:0] res;
        int             scyc;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    logic [2*N-1:0] last_res = '0;
    int             done_count = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare each completion against the oldest expectation; outputs must hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_while_busy", {63'b0, done & busy}, 64'd0);
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done expected=no_done (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", {32'b0, mul_hi, mul_rd}, {32'b0, mon_e.res});
                    chk("latency", 64'(cyc - mon_e.scyc), 64'(N));
                    last_res = mon_e.res;
                end
            end else begin
                chk("hold", {32'b0, mul_hi, mul_rd}, {32'b0, last_res});
            end
        end
    end

    // Present operands for one edge; the caller guarantees the unit is idle at that edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        exp_t e;
        rs1_reg = a;
        rs2_reg = b;
        acc_in  = c;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e.res   = (2*N)'(a) * (2*N)'(b) + (2*N)'(c);
        e.scyc  = cyc;
        sb.push_back(e);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        rs1_reg = N'($urandom);
        rs2_reg = N'($urandom);
        acc_in  = N'($urandom);
    endtask

    // Returns at the negedge where done is seen, or flags a timeout.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d1;
        int dc0;
        logic [N-1:0] dv, vv, q, r;

        repeat (2) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_out", {32'b0, mul_hi, mul_rd}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'd7, 16'd3, 16'd2);
        wait_done();
        chk("small_rd", {48'b0, mul_rd}, 64'h17);
        chk("small_hi", {48'b0, mul_hi}, 64'h0);

        issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done();
        chk("max_hi", {48'b0, mul_hi}, 64'hFFFF);
        chk("max_rd", {48'b0, mul_rd}, 64'h0);

        issue(16'h0000, 16'h1234, 16'h0000);
        wait_done();
        chk("zero_a", {32'b0, mul_hi, mul_rd}, 64'd0);
        issue(16'h1234, 16'h0000, 16'h0005);
        wait_done();
        chk("zero_b", {32'b0, mul_hi, mul_rd}, 64'd5);

        // start re-asserted mid-operation with different operands must be ignored
        @(negedge clk);
        dc0 = done_count;
        issue(16'hABCD, 16'h1357, 16'h0042);
        repeat (2) @(posedge clk);
        #1;
        rs1_reg = 16'h1111; rs2_reg = 16'h2222; acc_in = 16'h3333; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rs1_reg = 16'h4444; rs2_reg = 16'h5555; acc_in = 16'h6666; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("single_done", 64'(done_count - dc0), 64'd1);

        // reset in flight: discarded, no done
        dc0 = done_count;
        issue(16'h00FF, 16'h00FF, 16'h0001);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_res = '0;
        #1;
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_done", {63'b0, done}, 64'd0);
        chk("mid_rst_out", {32'b0, mul_hi, mul_rd}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("no_done_after_rst", 64'(done_count - dc0), 64'd0);
        issue(16'h0102, 16'h0304, 16'h0506);
        wait_done();

        // back-to-back: second start presented during the done cycle
        issue(16'hBEEF, 16'hCAFE, 16'h1234);
        wait_done();
        d1 = cyc;
        issue(16'h8001, 16'h7FFF, 16'hFFFF);
        wait_done();
        chk("b2b_spacing", 64'(cyc - d1), 64'(N + 1));

        // fully random operands, back-to-back
        for (int i = 0; i < 200; i++) begin
            issue(N'($urandom), N'($urandom), N'($urandom));
            wait_done();
        end

        // div round trip: q * v + r reconstructs the dividend
        for (int i = 0; i < 1000; i++) begin
            dv = N'($urandom_range(0, 65535));
            vv = N'($urandom_range(1, 65535));
            q  = dv / vv;
            r  = dv % vv;
            issue(q, vv, r);
            wait_done();
            chk("roundtrip", {32'b0, mul_hi, mul_rd}, {48'b0, dv});
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
